sprite_anim_ctrl: RTL and testbench

// Sequences a palettized character sprite: picks which animation frame ROM is shown
// (idle loop, one-shot attack, cooldown) and generates the per-pixel ROM address and

---
 rtl/sprite_anim_ctrl.sv | 155 +++++++++++++++
 tb/tb_sprite_anim_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation sequencer (idle loop, one-shot attack, cooldown) and per-pixel
// ROM address / in-box flag generator for a sprite on the 640x480 raster.
module sprite_anim_ctrl #(
    parameter int SPR_W       = 54,
    parameter int SPR_H       = 160,
    parameter int ADDR_W      = 14,
    parameter int IDLE_FRAMES = 2,
    parameter int ATK_FRAMES  = 4,
    parameter int HOLD_VSYNC  = 8,
    parameter int COOL_VSYNC  = 16
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              vsync_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              attack_req,
    output logic [1:0]        anim_state,
    output logic [2:0]        frame_idx,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on,
    output logic              busy
);
    localparam int HW = (HOLD_VSYNC > 1) ? $clog2(HOLD_VSYNC) : 1;
    localparam int CW = (COOL_VSYNC > 1) ? $clog2(COOL_VSYNC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_VSYNC - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOL_VSYNC - 1);
    localparam logic [2:0]    IDLE_LAST = 3'(IDLE_FRAMES - 1);
    localparam logic [2:0]    ATK_LAST  = 3'(ATK_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ATTACK = 2'd1,
        S_COOL   = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     frame_nxt;
    logic [HW-1:0]  hold, hold_nxt;
    logic [CW-1:0]  cool, cool_nxt;
    logic           pending, pending_nxt;
    logic [9:0]     px, py;

    // ---------------- pixel path ----------------
    // 11-bit compare so px+SPR_W past 639 clips instead of wrapping
    logic [10:0]       x11, y11, px11, py11;
    logic              in_box;
    logic [ADDR_W-1:0] dx, dy, addr_c;

    assign x11  = {1'b0, DrawX};
    assign y11  = {1'b0, DrawY};
    assign px11 = {1'b0, px};
    assign py11 = {1'b0, py};
    assign in_box = (x11 >= px11) && (x11 < px11 + 11'(SPR_W)) &&
                    (y11 >= py11) && (y11 < py11 + 11'(SPR_H));
    assign dx     = ADDR_W'(DrawX) - ADDR_W'(px);
    assign dy     = ADDR_W'(DrawY) - ADDR_W'(py);
    assign addr_c = dy * ADDR_W'(SPR_W) + dx;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            px          <= '0;
            py          <= '0;
            rom_address <= '0;
            sprite_on   <= 1'b0;
        end else begin
            if (vsync_start) begin
                px <= pos_x;
                py <= pos_y;
            end
            sprite_on   <= in_box;
            rom_address <= in_box ? addr_c : '0;
        end
    end

    // ---------------- animation FSM ----------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            frame_idx <= '0;
            hold      <= '0;
            cool      <= '0;
            pending   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_idx <= frame_nxt;
            hold      <= hold_nxt;
            cool      <= cool_nxt;
            pending   <= pending_nxt;
            busy      <= (state_nxt == S_ATTACK) || (state_nxt == S_COOL);
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame_idx;
        hold_nxt    = hold;
        cool_nxt    = cool;
        pending_nxt = pending;
        if (state == S_IDLE && attack_req)
            pending_nxt = 1'b1;
        case (state)
            S_IDLE: if (vsync_start) begin
                // a request latched earlier wins; one arriving now waits a frame
                if (pending) begin
                    state_nxt   = S_ATTACK;
                    frame_nxt   = '0;
                    hold_nxt    = '0;
                    pending_nxt = 1'b0;
                end else if (hold == HOLD_LAST) begin
                    hold_nxt  = '0;
                    frame_nxt = (frame_idx == IDLE_LAST) ? 3'd0 : frame_idx + 3'd1;
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end
            S_ATTACK: if (vsync_start) begin
                if (hold == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (frame_idx == ATK_LAST) begin
                        state_nxt = S_COOL;
                        cool_nxt  = '0;
                        frame_nxt = '0;
                    end else begin
                        frame_nxt = frame_idx + 3'd1;
                    end
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end
            S_COOL: if (vsync_start) begin
                if (cool == COOL_LAST) begin
                    state_nxt = S_IDLE;
                    frame_nxt = '0;
                    hold_nxt  = '0;
                end else begin
                    cool_nxt = cool + CW'(1);
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                frame_nxt   = '0;
                hold_nxt    = '0;
                cool_nxt    = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    assign anim_state = state;
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench for sprite_anim_ctrl: pixel address path and animation sequencing.
module tb_sprite_anim_ctrl;
    localparam int SPR_W  = 54;
    localparam int SPR_H  = 160;
    localparam int ADDR_W = 14;

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [9:0]        DrawX = 10'd10, DrawY = 10'd10;
    logic              vsync_start = 1'b0;
    logic [9:0]        pos_x = '0, pos_y = '0;
    logic              attack_req = 1'b0;
    logic [1:0]        anim_state;
    logic [2:0]        frame_idx;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_on;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int px_m = 0, py_m = 0;

    logic [ADDR_W:0] pix_q[$];
    logic [5:0]      fsm_q[$];

    sprite_anim_ctrl dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .vsync_start(vsync_start), .pos_x(pos_x), .pos_y(pos_y), .attack_req(attack_req),
        .anim_state(anim_state), .frame_idx(frame_idx), .rom_address(rom_address),
        .sprite_on(sprite_on), .busy(busy)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [ADDR_W:0] pix_exp(input int x, input int y);
        if (x >= px_m && x < px_m + SPR_W && y >= py_m && y < py_m + SPR_H)
            return {1'b1, ADDR_W'((y - py_m) * SPR_W + (x - px_m))};
        return '0;
    endfunction

    task automatic pix(input string tag, input int x, input int y);
        logic [ADDR_W:0] e;
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_q.push_back(pix_exp(x, y));
        @(posedge vga_clk);
        #1;
        e = pix_q.pop_front();
        chk({tag, "_on"}, 32'(sprite_on), 32'(e[ADDR_W]));
        chk({tag, "_addr"}, 32'(rom_address), 32'(e[ADDR_W-1:0]));
    endtask

    task automatic vs(input logic req);
        @(negedge vga_clk);
        vsync_start = 1'b1;
        attack_req  = req;
        px_m = int'(pos_x);
        py_m = int'(pos_y);
        @(negedge vga_clk);
        vsync_start = 1'b0;
        attack_req  = 1'b0;
    endtask

    task automatic vs_chk(input string tag, input logic req, input int st, input int fr, input int bz);
        logic [5:0] e;
        fsm_q.push_back({1'(bz), 2'(st), 3'(fr)});
        vs(req);
        e = fsm_q.pop_front();
        chk({tag, "_state"}, 32'(anim_state), 32'(e[4:3]));
        chk({tag, "_frame"}, 32'(frame_idx), 32'(e[2:0]));
        chk({tag, "_busy"}, 32'(busy), 32'(e[5]));
    endtask

    task automatic pulse_req();
        @(negedge vga_clk);
        attack_req = 1'b1;
        @(negedge vga_clk);
        attack_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        reset_n = 1'b0;
        px_m = 0;
        py_m = 0;
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held mid-raster with the pixel inside the default box
        repeat (3) @(negedge vga_clk);
        chk("rst_state", 32'(anim_state), 0);
        chk("rst_frame", 32'(frame_idx), 0);
        chk("rst_on", 32'(sprite_on), 0);
        chk("rst_addr", 32'(rom_address), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        pix("rst_px0", 0, 0);

        // idle loop toggles every 8 vsyncs
        for (int k = 1; k <= 24; k++)
            vs_chk("idle", 1'b0, 0, (k / 8) % 2, 0);

        // address path
        pos_x = 10'd100; pos_y = 10'd50;
        vs(1'b0);
        pix("a_org", 100, 50);
        pix("a_far", 153, 209);
        chk("a_far_const", 32'(rom_address), 8639);
        @(negedge vga_clk);
        DrawX = 10'd154;
        #1;
        chk("a_lag_on", 32'(sprite_on), 1);
        chk("a_lag_addr", 32'(rom_address), 8639);
        pix("a_right", 154, 209);
        pix("a_left", 99, 50);
        pix("a_top", 100, 49);
        pix("a_bot", 100, 210);

        // position change mid-frame is ignored until vsync
        pix("m_pre", 120, 200);
        pos_x = 10'd300;
        pix("m_old", 100, 200);
        chk("m_old_const", 32'(sprite_on), 1);
        vs(1'b0);
        pix("m_new_off", 100, 200);
        pix("m_new_on", 300, 200);
        chk("m_new_const", 32'(rom_address), 8100);

        // right/bottom clipping
        pos_x = 10'd600; pos_y = 10'd400;
        vs(1'b0);
        pix("c_corner", 639, 479);
        chk("c_corner_const", 32'(rom_address), 4305);
        pix("c_nowrap", 10, 479);
        pix("c_org", 600, 400);
        pix("c_left", 599, 400);

        // attack sequence, with requests during ATTACK/COOLDOWN ignored
        do_reset();
        pulse_req();
        chk("k_wait_state", 32'(anim_state), 0);
        for (int k = 1; k <= 49; k++) begin
            if (k <= 32)      vs_chk("atk", 1'b0, 1, (k - 1) / 8, 1);
            else if (k <= 48) vs_chk("cool", 1'b0, 2, 0, 1);
            else              vs_chk("back", 1'b0, 0, 0, 0);
            if (k == 10 || k == 40) pulse_req();
        end
        for (int n = 1; n <= 10; n++)
            vs_chk("noretrig", 1'b0, 0, (n / 8) % 2, 0);

        // request coincident with vsync lands one frame later
        do_reset();
        vs_chk("col_same", 1'b1, 0, 0, 0);
        vs_chk("col_next", 1'b0, 1, 0, 1);
        vs_chk("col_hold", 1'b0, 1, 0, 1);

        // asynchronous reset mid-attack
        @(negedge vga_clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_state", 32'(anim_state), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_frame", 32'(frame_idx), 0);
        px_m = 0; py_m = 0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        vs_chk("ar_idle", 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
